test_pattern_checker: RTL and testbench

Receiver-side checker for the 10-bit incrementing test pattern driven onto the sample bus when test mode is active. It locks onto the modulo-1024 ramp, flags every out-of-sequence sample, and keeps saturating error and sample counts. It sits downstream of the sample source, before the sample FIFO, and is used for bench and field verification of the sample data path.

---
 rtl/test_pattern_checker.sv | 177 +++++++++++++++++
 tb/tb_test_pattern_checker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/test_pattern_checker.sv
// -----------------------------------------------------------------------------
// test_pattern_checker
//
// Receiver-side checker for the incrementing (modulo 2^DATA_WIDTH) test ramp
// driven onto the sample bus in test mode. It searches for the ramp, locks
// after LOCK_COUNT consecutive in-sequence samples, then flywheels its own
// expected value. While locked it flags every out-of-sequence sample. It drops
// back to SEARCH after LOSS_COUNT consecutive mismatches.
//
// State table:
//   state  | meaning
//   SEARCH | tracking the last received sample, counting in-sequence runs
//   LOCKED | flywheel reference advancing once per valid sample, errors flagged
//
// Ports:
//   nReset           in   async active-low reset
//   clock            in   sample clock, rising edge
//   dataIn           in   sample under test
//   dataValid        in   dataIn is valid this cycle
//   enable           in   checker active; low forces SEARCH, freezes counters
//   clearCounters    in   sync clear of counts and first-error capture
//   locked           out  high while LOCKED
//   errorPulse       out  one-cycle strobe per mismatch while LOCKED
//   errorCount       out  saturating mismatch count since clear
//   sampleCount      out  saturating count of valid samples while enabled
//   firstErrExpected out  expected value at first mismatch since clear
//   firstErrReceived out  received value at first mismatch since clear
//   firstErrValid    out  firstErr* hold a capture
// -----------------------------------------------------------------------------
module test_pattern_checker #(
  parameter int DATA_WIDTH = 10,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_WIDTH  = 16,
  parameter int SMP_WIDTH  = 32
) (
  input  logic                  nReset,
  input  logic                  clock,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  dataValid,
  input  logic                  enable,
  input  logic                  clearCounters,
  output logic                  locked,
  output logic                  errorPulse,
  output logic [ERR_WIDTH-1:0]  errorCount,
  output logic [SMP_WIDTH-1:0]  sampleCount,
  output logic [DATA_WIDTH-1:0] firstErrExpected,
  output logic [DATA_WIDTH-1:0] firstErrReceived,
  output logic                  firstErrValid
);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0] LOCK_TH = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_TH = 4'(LOSS_COUNT);
  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state;
  logic [DATA_WIDTH-1:0]   refVal;
  logic                    seeded;
  logic [3:0]              runCount;
  logic [3:0]              badCount;

  logic [DATA_WIDTH-1:0]   nextRef;
  logic                    isMatch;
  logic                    takeSample;
  logic                    lockedMismatch;
  logic                    errSat;
  logic                    smpSat;

  // Wraps naturally at the data width, so max -> 0 counts as in-sequence.
  assign nextRef        = refVal + ONE;
  assign isMatch        = (dataIn == nextRef);
  assign takeSample     = enable & dataValid;
  assign lockedMismatch = takeSample & (state == LOCKED) & ~isMatch;
  assign errSat         = &errorCount;
  assign smpSat         = &sampleCount;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state            <= SEARCH;
      refVal           <= '0;
      seeded           <= 1'b0;
      runCount         <= '0;
      badCount         <= '0;
      locked           <= 1'b0;
      errorPulse       <= 1'b0;
      errorCount       <= '0;
      sampleCount      <= '0;
      firstErrExpected <= '0;
      firstErrReceived <= '0;
      firstErrValid    <= 1'b0;
    end else begin
      // The strobe reports the mismatch even when a clear lands on the same
      // edge; only the counts and capture are suppressed by the clear.
      errorPulse <= lockedMismatch;

      if (clearCounters) begin
        errorCount       <= '0;
        sampleCount      <= '0;
        firstErrExpected <= '0;
        firstErrReceived <= '0;
        firstErrValid    <= 1'b0;
      end else begin
        if (takeSample && !smpSat) begin
          sampleCount <= sampleCount + 1'b1;
        end
        if (lockedMismatch) begin
          if (!errSat) begin
            errorCount <= errorCount + 1'b1;
          end
          if (!firstErrValid) begin
            firstErrExpected <= nextRef;
            firstErrReceived <= dataIn;
            firstErrValid    <= 1'b1;
          end
        end
      end

      if (!enable) begin
        // Drop the seed so the first sample after re-enable only loads refVal.
        state    <= SEARCH;
        seeded   <= 1'b0;
        runCount <= '0;
        badCount <= '0;
        locked   <= 1'b0;
      end else if (dataValid) begin
        case (state)
          SEARCH: begin
            refVal <= dataIn;
            seeded <= 1'b1;
            if (!seeded) begin
              runCount <= '0;
            end else if (isMatch) begin
              if (runCount + 4'd1 == LOCK_TH) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                runCount <= '0;
                badCount <= '0;
              end else begin
                runCount <= runCount + 4'd1;
              end
            end else begin
              runCount <= '0;
            end
          end
          LOCKED: begin
            if (isMatch) begin
              badCount <= '0;
              refVal   <= nextRef;
            end else if (badCount + 4'd1 == LOSS_TH) begin
              // The sample that breaks lock seeds the new search.
              state    <= SEARCH;
              locked   <= 1'b0;
              refVal   <= dataIn;
              seeded   <= 1'b1;
              runCount <= '0;
              badCount <= '0;
            end else begin
              // Flywheel: advance regardless, so one corrupt sample is one error.
              badCount <= badCount + 4'd1;
              refVal   <= nextRef;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_test_pattern_checker.sv
module tb_test_pattern_checker;

  logic        nReset;
  logic        clock;
  logic [9:0]  dataIn;
  logic        dataValid;
  logic        enable;
  logic        clearCounters;

  logic        locked;
  logic        errorPulse;
  logic [15:0] errorCount;
  logic [31:0] sampleCount;
  logic [9:0]  firstErrExpected;
  logic [9:0]  firstErrReceived;
  logic        firstErrValid;

  // Second instance: narrow error counter and deep loss threshold to reach saturation.
  logic        locked2;
  logic        errorPulse2;
  logic [3:0]  errorCount2;
  logic [31:0] sampleCount2;
  logic [9:0]  firstErrExpected2;
  logic [9:0]  firstErrReceived2;
  logic        firstErrValid2;

  int errors = 0;
  int checks = 0;

  test_pattern_checker dut (
    .nReset(nReset), .clock(clock), .dataIn(dataIn), .dataValid(dataValid),
    .enable(enable), .clearCounters(clearCounters),
    .locked(locked), .errorPulse(errorPulse), .errorCount(errorCount),
    .sampleCount(sampleCount), .firstErrExpected(firstErrExpected),
    .firstErrReceived(firstErrReceived), .firstErrValid(firstErrValid)
  );

  test_pattern_checker #(.LOSS_COUNT(15), .ERR_WIDTH(4)) dutSat (
    .nReset(nReset), .clock(clock), .dataIn(dataIn), .dataValid(dataValid),
    .enable(enable), .clearCounters(clearCounters),
    .locked(locked2), .errorPulse(errorPulse2), .errorCount(errorCount2),
    .sampleCount(sampleCount2), .firstErrExpected(firstErrExpected2),
    .firstErrReceived(firstErrReceived2), .firstErrValid(firstErrValid2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one sample, let one rising edge pass, sample outputs 1 ns later.
  task automatic send(input logic [9:0] v, input logic vld);
    dataIn    = v;
    dataValid = vld;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    nReset = 1'b0; dataIn = '0; dataValid = 1'b0; enable = 1'b1; clearCounters = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%0b want=0", locked); end
    checks++; if (errorPulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%0b want=0", errorPulse); end
    checks++; if (errorCount !== 16'd0) begin errors++; $display("FAIL reset_errcnt got=%0d want=0", errorCount); end
    checks++; if (sampleCount !== 32'd0) begin errors++; $display("FAIL reset_smpcnt got=%0d want=0", sampleCount); end
    checks++; if (firstErrValid !== 1'b0) begin errors++; $display("FAIL reset_fev got=%0b want=0", firstErrValid); end
    @(negedge clock);
    nReset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_lock();
    for (int i = 0; i < 4; i++) send(10'(i), 1'b1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got=%0b want=0", locked); end
    send(10'd4, 1'b1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_rise got=%0b want=1", locked); end
    checks++; if (sampleCount !== 32'd5) begin errors++; $display("FAIL lock_smpcnt got=%0d want=5", sampleCount); end
    checks++; if (errorCount !== 16'd0) begin errors++; $display("FAIL lock_errcnt got=%0d want=0", errorCount); end
    for (int i = 5; i < 10; i++) send(10'(i), 1'b1);
    checks++; if (sampleCount !== 32'd10) begin errors++; $display("FAIL lock_smpcnt10 got=%0d want=10", sampleCount); end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    send(10'd10, 1'b1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL dis_locked got=%0b want=0", locked); end
    checks++; if (sampleCount !== 32'd10) begin errors++; $display("FAIL dis_smpcnt got=%0d want=10", sampleCount); end
    enable = 1'b1;
  endtask

  task automatic test_wrap();
    for (int i = 1017; i <= 1020; i++) send(10'(i), 1'b1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL wrap_prelock got=%0b want=0", locked); end
    send(10'd1021, 1'b1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL wrap_lock got=%0b want=1", locked); end
    send(10'd1022, 1'b1);
    checks++; if (errorPulse !== 1'b0) begin errors++; $display("FAIL wrap_1022 pulse got=%0b want=0", errorPulse); end
    send(10'd1023, 1'b1);
    checks++; if (errorPulse !== 1'b0) begin errors++; $display("FAIL wrap_1023 pulse got=%0b want=0", errorPulse); end
    send(10'd0, 1'b1);
    checks++; if (errorPulse !== 1'b0) begin errors++; $display("FAIL wrap_0 pulse got=%0b want=0", errorPulse); end
    send(10'd1, 1'b1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL wrap_locked got=%0b want=1", locked); end
    checks++; if (errorCount !== 16'd0) begin errors++; $display("FAIL wrap_errcnt got=%0d want=0", errorCount); end
    checks++; if (sampleCount !== 32'd19) begin errors++; $display("FAIL wrap_smpcnt got=%0d want=19", sampleCount); end
  endtask

  task automatic test_single_error();
    clearCounters = 1'b1;
    send(10'd0, 1'b0);
    clearCounters = 1'b0;
    checks++; if (sampleCount !== 32'd0) begin errors++; $display("FAIL clr_smpcnt got=%0d want=0", sampleCount); end
    for (int i = 2; i <= 100; i++) begin
      send(10'(i), 1'b1);
      checks++; if (errorPulse !== 1'b0) begin errors++; $display("FAIL ramp_pulse at=%0d got=%0b want=0", i, errorPulse); end
    end
    send(10'd101, 1'b1);
    send(10'd555, 1'b1);
    checks++; if (errorPulse !== 1'b1) begin errors++; $display("FAIL single_pulse got=%0b want=1", errorPulse); end
    checks++; if (errorCount !== 16'd1) begin errors++; $display("FAIL single_errcnt got=%0d want=1", errorCount); end
    checks++; if (firstErrExpected !== 10'd102) begin errors++; $display("FAIL single_fee got=%0d want=102", firstErrExpected); end
    checks++; if (firstErrReceived !== 10'd555) begin errors++; $display("FAIL single_fer got=%0d want=555", firstErrReceived); end
    checks++; if (firstErrValid !== 1'b1) begin errors++; $display("FAIL single_fev got=%0b want=1", firstErrValid); end
    send(10'd103, 1'b1);
    checks++; if (errorPulse !== 1'b0) begin errors++; $display("FAIL single_103 pulse got=%0b want=0", errorPulse); end
    send(10'd104, 1'b1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked got=%0b want=1", locked); end
    checks++; if (errorCount !== 16'd1) begin errors++; $display("FAIL single_errcnt2 got=%0d want=1", errorCount); end
    checks++; if (sampleCount !== 32'd103) begin errors++; $display("FAIL single_smpcnt got=%0d want=103", sampleCount); end
  endtask

  task automatic test_valid_gaps();
    send(10'd105, 1'b1);
    send(10'd999, 1'b0);
    checks++; if (errorPulse !== 1'b0) begin errors++; $display("FAIL gap_pulse got=%0b want=0", errorPulse); end
    checks++; if (sampleCount !== 32'd104) begin errors++; $display("FAIL gap_smpcnt got=%0d want=104", sampleCount); end
    send(10'd106, 1'b1);
    send(10'd888, 1'b0);
    send(10'd107, 1'b1);
    checks++; if (sampleCount !== 32'd106) begin errors++; $display("FAIL gap_smpcnt2 got=%0d want=106", sampleCount); end
    checks++; if (errorCount !== 16'd1) begin errors++; $display("FAIL gap_errcnt got=%0d want=1", errorCount); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL gap_locked got=%0b want=1", locked); end
  endtask

  task automatic test_clear_with_error();
    clearCounters = 1'b1;
    send(10'd500, 1'b1);
    clearCounters = 1'b0;
    checks++; if (errorPulse !== 1'b1) begin errors++; $display("FAIL clrerr_pulse got=%0b want=1", errorPulse); end
    checks++; if (errorCount !== 16'd0) begin errors++; $display("FAIL clrerr_errcnt got=%0d want=0", errorCount); end
    checks++; if (firstErrValid !== 1'b0) begin errors++; $display("FAIL clrerr_fev got=%0b want=0", firstErrValid); end
    checks++; if (sampleCount !== 32'd0) begin errors++; $display("FAIL clrerr_smpcnt got=%0d want=0", sampleCount); end
    send(10'd109, 1'b1);
    checks++; if (errorPulse !== 1'b0) begin errors++; $display("FAIL clrerr_next pulse got=%0b want=0", errorPulse); end
    checks++; if (sampleCount !== 32'd1) begin errors++; $display("FAIL clrerr_next smpcnt got=%0d want=1", sampleCount); end
  endtask

  task automatic test_loss_relock();
    send(10'd7, 1'b1);
    checks++; if (firstErrExpected !== 10'd110) begin errors++; $display("FAIL loss_fee got=%0d want=110", firstErrExpected); end
    checks++; if (firstErrReceived !== 10'd7) begin errors++; $display("FAIL loss_fer got=%0d want=7", firstErrReceived); end
    send(10'd7, 1'b1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_hold got=%0b want=1", locked); end
    send(10'd7, 1'b1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_fall got=%0b want=0", locked); end
    checks++; if (errorCount !== 16'd3) begin errors++; $display("FAIL loss_errcnt got=%0d want=3", errorCount); end
    send(10'd8, 1'b1);
    send(10'd9, 1'b1);
    send(10'd10, 1'b1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early got=%0b want=0", locked); end
    send(10'd11, 1'b1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock got=%0b want=1", locked); end
    send(10'd12, 1'b1);
    checks++; if (errorPulse !== 1'b0) begin errors++; $display("FAIL relock_12 pulse got=%0b want=0", errorPulse); end
    checks++; if (errorCount !== 16'd3) begin errors++; $display("FAIL relock_errcnt got=%0d want=3", errorCount); end
  endtask

  task automatic test_saturation();
    nReset = 1'b0;
    #2;
    nReset = 1'b1;
    @(negedge clock);
    for (int i = 0; i <= 4; i++) send(10'(i), 1'b1);
    checks++; if (locked2 !== 1'b1) begin errors++; $display("FAIL sat_lock got=%0b want=1", locked2); end
    for (int i = 0; i < 14; i++) send(10'd0, 1'b1);
    checks++; if (errorCount2 !== 4'd14) begin errors++; $display("FAIL sat_14 got=%0d want=14", errorCount2); end
    checks++; if (locked2 !== 1'b1) begin errors++; $display("FAIL sat_locked got=%0b want=1", locked2); end
    send(10'd19, 1'b1);
    checks++; if (errorPulse2 !== 1'b0) begin errors++; $display("FAIL sat_match pulse got=%0b want=0", errorPulse2); end
    send(10'd0, 1'b1);
    checks++; if (errorCount2 !== 4'd15) begin errors++; $display("FAIL sat_15 got=%0d want=15", errorCount2); end
    send(10'd0, 1'b1);
    checks++; if (errorCount2 !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d want=15", errorCount2); end
    checks++; if (errorPulse2 !== 1'b1) begin errors++; $display("FAIL sat_pulse got=%0b want=1", errorPulse2); end
  endtask

  task automatic test_midstream_reset();
    send(10'd300, 1'b1);
    send(10'd301, 1'b1);
    #2;
    nReset = 1'b0;
    #1;
    checks++; if (sampleCount !== 32'd0) begin errors++; $display("FAIL mrst_smpcnt got=%0d want=0", sampleCount); end
    checks++; if (errorCount !== 16'd0) begin errors++; $display("FAIL mrst_errcnt got=%0d want=0", errorCount); end
    checks++; if (firstErrValid !== 1'b0) begin errors++; $display("FAIL mrst_fev got=%0b want=0", firstErrValid); end
    checks++; if (firstErrReceived !== 10'd0) begin errors++; $display("FAIL mrst_fer got=%0d want=0", firstErrReceived); end
    checks++; if (errorCount2 !== 4'd0) begin errors++; $display("FAIL mrst_errcnt2 got=%0d want=0", errorCount2); end
    @(negedge clock);
    nReset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_enable();
    test_wrap();
    test_single_error();
    test_valid_gaps();
    test_clear_with_error();
    test_loss_relock();
    test_saturation();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
